// File: rtl/sp_sram_pkg.sv
// Shared types, defaults and ring-address helper for the sp_sram_ring slice.
package sp_sram_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_DEPTH  = 10;
    localparam int unsigned DEF_ADDR_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } stateE;

    // Physical slot of the word written (off+1) ring writes ago; requires ptr, off < depth.
    function automatic int unsigned ringAddr(input int unsigned ptr,
                                             input int unsigned off,
                                             input int unsigned depth);
        int unsigned phys;
        phys = ptr + depth - 32'd1 - off;
        if (phys >= depth) begin
            phys = phys - depth;
        end
        return phys;
    endfunction

endpackage

// File: rtl/sp_sram_ring_if.sv
// Access bus of sp_sram_ring: requester side (master) and memory side (slave).
interface sp_sram_ring_if
    import sp_sram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
);
    logic              iCsnRam;
    logic              iWrnRam;
    logic              iModeRing;
    logic [ADDR_W-1:0] iAddrRam;
    logic [DATA_W-1:0] iWtDtRam;
    logic              iClrRam;
    logic [DATA_W-1:0] oRdDtRam;
    logic              oRdVld;
    logic              oBusy;
    logic [ADDR_W-1:0] oWrPtr;

    modport master (
        output iCsnRam, iWrnRam, iModeRing, iAddrRam, iWtDtRam, iClrRam,
        input  oRdDtRam, oRdVld, oBusy, oWrPtr
    );

    modport slave (
        input  iCsnRam, iWrnRam, iModeRing, iAddrRam, iWtDtRam, iClrRam,
        output oRdDtRam, oRdVld, oBusy, oWrPtr
    );
endinterface

// File: rtl/sp_sram_core.sv
// Plain DEPTH x DATA_W storage: one synchronous write port, one registered read port.
// Kept free of control logic so it can be swapped for a vendor macro.
module sp_sram_core
    import sp_sram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk12M,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge Clk12M) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
        if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/sp_sram_ring.sv
// Single-port SRAM with direct/ring addressing and a sequential clear sweep.
// Define SP_SRAM_RESET_CLR_EN to run a clear sweep automatically after every reset.
module sp_sram_ring
    import sp_sram_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned DEPTH  = DEF_DEPTH,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic iClk12M,
    input  logic iRst,
    sp_sram_ring_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    stateE             state, stateNext;
    logic [ADDR_W-1:0] sweepCnt, sweepNext;
    logic [ADDR_W-1:0] wrPtr, wrPtrNext;
    logic              busyQ;
    logic              rdVldQ, rdVldNext;
    logic              rdZeroQ, rdZeroNext;
    logic              clrReq;
    logic              inRange;
    logic [ADDR_W-1:0] ringRdAddr;

    logic              memWe;
    logic [ADDR_W-1:0] memWAddr;
    logic [DATA_W-1:0] memWData;
    logic              memRe;
    logic [ADDR_W-1:0] memRAddr;
    logic [DATA_W-1:0] memRData;

`ifdef SP_SRAM_RESET_CLR_EN
    // Set by reset so the first cycle after release starts a sweep.
    logic pendClr;

    always_ff @(posedge iClk12M) begin
        pendClr <= iRst;
    end

    assign clrReq = bus.iClrRam | pendClr;
`else
    assign clrReq = bus.iClrRam;
`endif

    assign inRange    = 32'(bus.iAddrRam) < DEPTH;
    assign ringRdAddr = ADDR_W'(ringAddr(32'(wrPtr), 32'(bus.iAddrRam), DEPTH));

    always_comb begin
        stateNext  = state;
        sweepNext  = sweepCnt;
        wrPtrNext  = wrPtr;
        rdVldNext  = 1'b0;
        rdZeroNext = rdZeroQ;
        memWe      = 1'b0;
        memWAddr   = '0;
        memWData   = '0;
        memRe      = 1'b0;
        memRAddr   = '0;
        case (state)
            ST_IDLE: begin
                if (clrReq) begin
                    stateNext = ST_CLEAR;
                    sweepNext = '0;
                    wrPtrNext = '0;
                end else if (!bus.iCsnRam) begin
                    if (bus.iWrnRam) begin
                        rdVldNext  = 1'b1;
                        rdZeroNext = !inRange;
                        memRe      = inRange;
                        memRAddr   = bus.iModeRing ? ringRdAddr : bus.iAddrRam;
                    end else if (bus.iModeRing) begin
                        memWe     = 1'b1;
                        memWAddr  = wrPtr;
                        memWData  = bus.iWtDtRam;
                        wrPtrNext = (wrPtr == LAST_ADDR) ? '0 : wrPtr + ADDR_W'(1);
                    end else begin
                        memWe    = inRange;
                        memWAddr = bus.iAddrRam;
                        memWData = bus.iWtDtRam;
                    end
                end
            end
            ST_CLEAR: begin
                memWe    = 1'b1;
                memWAddr = sweepCnt;
                if (sweepCnt == LAST_ADDR) begin
                    stateNext = ST_IDLE;
                    sweepNext = '0;
                end else begin
                    sweepNext = sweepCnt + ADDR_W'(1);
                end
            end
            default: stateNext = ST_IDLE;
        endcase
        // A reset edge must not disturb memory: an aborted sweep leaves later words intact.
        if (iRst) begin
            memWe = 1'b0;
            memRe = 1'b0;
        end
    end

    always_ff @(posedge iClk12M) begin
        if (iRst) begin
            state    <= ST_IDLE;
            sweepCnt <= '0;
            wrPtr    <= '0;
            busyQ    <= 1'b0;
            rdVldQ   <= 1'b0;
            rdZeroQ  <= 1'b1;
        end else begin
            state    <= stateNext;
            sweepCnt <= sweepNext;
            wrPtr    <= wrPtrNext;
            busyQ    <= (stateNext == ST_CLEAR);
            rdVldQ   <= rdVldNext;
            rdZeroQ  <= rdZeroNext;
        end
    end

    sp_sram_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) uCore (
        .Clk12M (iClk12M),
        .wrEn   (memWe),
        .wrAddr (memWAddr),
        .wrData (memWData),
        .rdEn   (memRe),
        .rdAddr (memRAddr),
        .rdData (memRData)
    );

    // Reset and out-of-range reads present zero without touching the macro's read register.
    assign bus.oRdDtRam = rdZeroQ ? '0 : memRData;
    assign bus.oRdVld   = rdVldQ;
    assign bus.oBusy    = busyQ;
    assign bus.oWrPtr   = wrPtr;

endmodule

// File: tb/tb_sp_sram_ring.sv
// Self-checking bench for sp_sram_ring: directed test-plan sequences plus random traffic
// compared every cycle against a word-level memory model.
module tb_sp_sram_ring;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 10;
    localparam int ADDR_W = 4;
`ifdef SP_SRAM_RESET_CLR_EN
    localparam bit RST_CLR = 1'b1;
`else
    localparam bit RST_CLR = 1'b0;
`endif

    logic clk;
    logic rst;
    int   nChecks = 0;
    int   nFail   = 0;
    bit   chkEn   = 1'b0;

    sp_sram_ring_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    sp_sram_ring #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .iClk12M (clk),
        .iRst    (rst),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Word-level model: memory array, ring pointer, remaining clear words.
    logic [DATA_W-1:0] mMem [DEPTH];
    bit                mKnown [DEPTH];
    int                mPtr = 0;
    int                clrLeft = 0;
    int                clrIdx = 0;
    bit                mPend = 1'b0;
    logic [DATA_W-1:0] eDat = '0;
    bit                eDatKnown = 1'b0;
    bit                eVld = 1'b0;
    bit                eBusy = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) mKnown[i] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        int a;
        int phys;
        if (rst) begin
            eVld = 1'b0; eBusy = 1'b0; eDat = '0; eDatKnown = 1'b1;
            mPtr = 0; clrLeft = 0; clrIdx = 0; mPend = RST_CLR;
        end else begin
            eVld = 1'b0;
            a = int'(bus.iAddrRam);
            if (clrLeft > 0) begin
                mMem[clrIdx] = '0; mKnown[clrIdx] = 1'b1;
                clrIdx++; clrLeft--;
            end else if (bus.iClrRam || mPend) begin
                clrLeft = DEPTH; clrIdx = 0; mPtr = 0;
            end else if (!bus.iCsnRam) begin
                if (bus.iWrnRam) begin
                    eVld = 1'b1;
                    if (a >= DEPTH) begin
                        eDat = '0; eDatKnown = 1'b1;
                    end else begin
                        phys = bus.iModeRing ? (((mPtr - 1 - a) % DEPTH) + DEPTH) % DEPTH : a;
                        eDat = mMem[phys]; eDatKnown = mKnown[phys];
                    end
                end else if (bus.iModeRing) begin
                    mMem[mPtr] = bus.iWtDtRam; mKnown[mPtr] = 1'b1;
                    mPtr = (mPtr + 1) % DEPTH;
                end else if (a < DEPTH) begin
                    mMem[a] = bus.iWtDtRam; mKnown[a] = 1'b1;
                end
            end
            mPend = 1'b0;
            eBusy = (clrLeft > 0);
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            check("vld", 32'(bus.oRdVld), 32'(eVld));
            check("busy", 32'(bus.oBusy), 32'(eBusy));
            check("wrptr", 32'(bus.oWrPtr), 32'(mPtr));
            if (eDatKnown) check("rddata", 32'(bus.oRdDtRam), 32'(eDat));
        end
    end

    task automatic idle();
        bus.iCsnRam = 1'b1; bus.iWrnRam = 1'b1; bus.iModeRing = 1'b0;
        bus.iAddrRam = '0; bus.iWtDtRam = '0; bus.iClrRam = 1'b0;
    endtask

    task automatic wr(input bit ring, input int addr, input logic [DATA_W-1:0] data);
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iModeRing = ring;
        bus.iAddrRam = ADDR_W'(addr); bus.iWtDtRam = data; bus.iClrRam = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input bit ring, input int addr, input logic [DATA_W-1:0] exp, input string name);
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b1; bus.iModeRing = ring;
        bus.iAddrRam = ADDR_W'(addr); bus.iClrRam = 1'b0;
        @(negedge clk);
        check(name, 32'(bus.oRdDtRam), 32'(exp));
        check({name, "_vld"}, 32'(bus.oRdVld), 32'd1);
    endtask

    // Counts cycles with oBusy high while issuing reads; flags any read strobe seen.
    task automatic countBusy(output int n, output bit sawVld);
        n = 0; sawVld = 1'b0;
        while (bus.oBusy && n < 30) begin
            bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b1; bus.iModeRing = 1'b0;
            bus.iAddrRam = ADDR_W'(n % DEPTH); bus.iClrRam = 1'b0;
            n++;
            @(negedge clk);
            if (bus.oRdVld) sawVld = 1'b1;
        end
        idle();
    endtask

    initial begin
        int  n;
        bit  sawVld;
        rst = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        chkEn = 1'b1;
        check("rst_busy", 32'(bus.oBusy), 32'd0);
        check("rst_vld", 32'(bus.oRdVld), 32'd0);
        check("rst_data", 32'(bus.oRdDtRam), 32'd0);
        check("rst_ptr", 32'(bus.oWrPtr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        countBusy(n, sawVld);
        check("boot_busy_cycles", 32'(n), RST_CLR ? 32'd10 : 32'd0);
        if (RST_CLR) for (int i = 0; i < DEPTH; i++) rd(1'b0, i, '0, "boot_zero");

        // Direct mode fill and back-to-back readback
        for (int i = 0; i < DEPTH; i++) wr(1'b0, i, DATA_W'(32'ha00 + i));
        for (int i = 0; i < DEPTH; i++) rd(1'b0, i, DATA_W'(32'ha00 + i), "direct_rd");

        // Out-of-range access
        wr(1'b0, 15, 16'hffff);
        rd(1'b0, 15, '0, "oor_rd");
        for (int i = 0; i < DEPTH; i++) rd(1'b0, i, DATA_W'(32'ha00 + i), "oor_keep");

        // Clear pulse with a simultaneous write that must be dropped
        bus.iCsnRam = 1'b0; bus.iWrnRam = 1'b0; bus.iModeRing = 1'b1;
        bus.iAddrRam = '0; bus.iWtDtRam = 16'h1234; bus.iClrRam = 1'b1;
        @(negedge clk);
        countBusy(n, sawVld);
        check("clr_busy_cycles", 32'(n), 32'd10);
        check("clr_no_vld", 32'(sawVld), 32'd0);
        check("clr_ptr", 32'(bus.oWrPtr), 32'd0);
        for (int i = 0; i < DEPTH; i++) rd(1'b0, i, '0, "clr_zero");

        // Ring mode
        for (int i = 1; i <= 12; i++) wr(1'b1, 0, DATA_W'(i));
        idle();
        @(negedge clk);
        check("ring_ptr", 32'(bus.oWrPtr), 32'd2);
        check("model_ptr", 32'(mPtr), 32'd2);
        rd(1'b1, 0, 16'd12, "ring_off0");
        rd(1'b1, 9, 16'd3, "ring_off9");
        rd(1'b1, 10, 16'd0, "ring_off10");

        // Reset four cycles into a sweep
        for (int i = 0; i < DEPTH; i++) wr(1'b0, i, DATA_W'(32'h500 + i));
        idle();
        bus.iClrRam = 1'b1;
        @(negedge clk);
        idle();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(bus.oBusy), 32'd0);
        check("abort_vld", 32'(bus.oRdVld), 32'd0);
        check("abort_data", 32'(bus.oRdDtRam), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        countBusy(n, sawVld);
        for (int i = 0; i < DEPTH; i++)
            rd(1'b0, i, (i < 4 || RST_CLR) ? '0 : DATA_W'(32'h500 + i), "abort_mem");

        // Random traffic checked by the per-cycle compare
        for (int k = 0; k < 800; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            bus.iClrRam   = ($urandom_range(0, 39) == 0);
            bus.iCsnRam   = ($urandom_range(0, 3) == 0);
            bus.iWrnRam   = 1'($urandom_range(0, 1));
            bus.iModeRing = 1'($urandom_range(0, 1));
            bus.iAddrRam  = ADDR_W'($urandom_range(0, 15));
            bus.iWtDtRam  = DATA_W'($urandom);
            @(negedge clk);
        end
        rst = 1'b0;
        idle();
        repeat (15) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
